// File: rtl/stack_memory_unit.sv
// stack_memory_unit
//   Data memory / stack unit for the memory stage. Serves word LOAD/STORE,
//   single-word PUSH/POP and multi-word PUSH_PC/POP_PC on a full-descending
//   stack (pre-decrement push, post-increment pop). PC transfers take WORDS
//   cycles and are sequenced by a two-state FSM (IDLE, XFER).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake; accepted when both high at posedge
//   op                  0 NOP,1 LOAD,2 STORE,3 PUSH,4 POP,5 PUSH_PC,6 POP_PC,7 NOP
//   addr, wdata, pc_in  request operands
//   rsp_valid           one-cycle completion pulse
//   rsp_data, rsp_pc    LOAD/POP word, POP_PC value (0 otherwise)
//   exc_overflow/_underflow  stack fault, qualified by rsp_valid
//   sp                  stack pointer; DEPTH means empty
module stack_memory_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   pc_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [PC_W-1:0]   rsp_pc,
  output logic              exc_overflow,
  output logic              exc_underflow,
  output logic [ADDR_W:0]   sp
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WORDS = PC_W / DATA_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SP_W  = ADDR_W + 1;

  localparam logic [ADDR_W:0] SP_EMPTY    = SP_W'(DEPTH);
  localparam logic [ADDR_W:0] SP_WORDS    = SP_W'(WORDS);
  localparam logic [ADDR_W:0] SP_POPW_MAX = SP_W'(DEPTH - WORDS);

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_PUSH   = 3'd3;
  localparam logic [2:0] OP_POP    = 3'd4;
  localparam logic [2:0] OP_PUSH_PC = 3'd5;
  localparam logic [2:0] OP_POP_PC  = 3'd6;

  if ((PC_W % DATA_W) != 0 || WORDS < 1) begin : g_bad_param
    $error("PC_W must be a non-zero multiple of DATA_W");
  end

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              xfer_push;
  // Holds the remaining PC words for a push (MSW at the top) or the
  // partially assembled PC for a pop (newest word at the top).
  logic [PC_W-1:0]   xfer_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W:0]   sp_dec;
  logic [ADDR_W:0]   sp_inc;
  logic [DATA_W-1:0] mem_top;
  logic [PC_W-1:0]   top_ext;
  logic [PC_W-1:0]   pop_next;
  logic              push1_ok;
  logic              pushw_ok;
  logic              pop1_ok;
  logic              popw_ok;

  assign req_ready = (state == IDLE);

  assign sp_dec  = sp - 1'b1;
  assign sp_inc  = sp + 1'b1;
  // sp == DEPTH aliases address 0 here; only used when a pop is legal.
  assign mem_top = mem[sp[ADDR_W-1:0]];

  assign push1_ok = (sp != '0);
  assign pushw_ok = (sp >= SP_WORDS);
  assign pop1_ok  = (sp < SP_EMPTY);
  assign popw_ok  = (sp <= SP_POPW_MAX);

  always_comb begin
    top_ext = '0;
    top_ext[DATA_W-1:0] = mem_top;
  end

  // Popped word enters at the top; after WORDS pops the first (LS) word
  // has been shifted down to bit 0.
  assign pop_next = (xfer_reg >> DATA_W) | (top_ext << (PC_W - DATA_W));

  // Write port: blocked under reset so an aborted transfer writes nothing
  // further, and blocked on any stack fault.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp_dec[ADDR_W-1:0];
    mem_wdata = wdata;
    if (!reset) begin
      if (state == IDLE) begin
        if (req_valid) begin
          case (op)
            OP_STORE: begin
              mem_we    = 1'b1;
              mem_waddr = addr;
            end
            OP_PUSH: mem_we = push1_ok;
            OP_PUSH_PC: begin
              mem_we    = pushw_ok;
              mem_wdata = pc_in[PC_W-1 -: DATA_W];
            end
            default: ;
          endcase
        end
      end else if (xfer_push) begin
        mem_we    = 1'b1;
        mem_wdata = xfer_reg[PC_W-1 -: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sp            <= SP_EMPTY;
      cnt           <= '0;
      xfer_push     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_pc        <= '0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_pc        <= '0;
      exc_overflow  <= 1'b0;
      exc_underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (op)
              OP_LOAD: begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem[addr];
              end
              OP_STORE: rsp_valid <= 1'b1;
              OP_PUSH: begin
                rsp_valid <= 1'b1;
                if (push1_ok) sp <= sp_dec;
                else          exc_overflow <= 1'b1;
              end
              OP_POP: begin
                rsp_valid <= 1'b1;
                if (pop1_ok) begin
                  rsp_data <= mem_top;
                  sp       <= sp_inc;
                end else begin
                  exc_underflow <= 1'b1;
                end
              end
              OP_PUSH_PC: begin
                if (!pushw_ok) begin
                  rsp_valid    <= 1'b1;
                  exc_overflow <= 1'b1;
                end else begin
                  sp <= sp_dec;
                  if (WORDS == 1) begin
                    rsp_valid <= 1'b1;
                  end else begin
                    state     <= XFER;
                    cnt       <= CNT_W'(WORDS - 2);
                    xfer_push <= 1'b1;
                    xfer_reg  <= pc_in << DATA_W;
                  end
                end
              end
              OP_POP_PC: begin
                if (!popw_ok) begin
                  rsp_valid     <= 1'b1;
                  exc_underflow <= 1'b1;
                end else begin
                  sp <= sp_inc;
                  if (WORDS == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_pc    <= pop_next;
                  end else begin
                    state     <= XFER;
                    cnt       <= CNT_W'(WORDS - 2);
                    xfer_push <= 1'b0;
                    xfer_reg  <= pop_next;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        XFER: begin
          if (xfer_push) begin
            sp       <= sp_dec;
            xfer_reg <= xfer_reg << DATA_W;
          end else begin
            sp       <= sp_inc;
            xfer_reg <= pop_next;
          end
          if (cnt == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            if (!xfer_push) rsp_pc <= pop_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_memory_unit.sv
// tb_stack_memory_unit
//   Scoreboard bench for stack_memory_unit (default parameters: 16-bit words,
//   1K depth, 32-bit PC). A reference model predicts each response when a
//   request is accepted; a negedge monitor pops and compares responses.
module tb_stack_memory_unit;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_STORE   = 3'd2;
  localparam logic [2:0] OP_PUSH    = 3'd3;
  localparam logic [2:0] OP_POP     = 3'd4;
  localparam logic [2:0] OP_PUSH_PC = 3'd5;
  localparam logic [2:0] OP_POP_PC  = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [9:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [31:0] pc_in = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [31:0] rsp_pc;
  logic        exc_overflow;
  logic        exc_underflow;
  logic [10:0] sp;

  always #5 clk = ~clk;

  stack_memory_unit dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .op(op),
    .addr(addr),
    .wdata(wdata),
    .pc_in(pc_in),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_pc(rsp_pc),
    .exc_overflow(exc_overflow),
    .exc_underflow(exc_underflow),
    .sp(sp)
  );

  typedef struct {
    logic [15:0] d;
    logic [31:0] p;
    logic        o;
    logic        u;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        mon_e;
  logic [15:0] m_mem [1024];
  int          m_sp = 1024;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.d));
        chk("rsp_pc", 64'(rsp_pc), 64'(mon_e.p));
        chk("exc_overflow", 64'(exc_overflow), 64'(mon_e.o));
        chk("exc_underflow", 64'(exc_underflow), 64'(mon_e.u));
      end
    end
  end

  // Drives one request, waits for acceptance, then updates the model and
  // queues the predicted response. Returns one time unit after the accept edge.
  task automatic send(input logic [2:0] o, input logic [9:0] a,
                      input logic [15:0] d, input logic [31:0] p);
    int   t;
    rsp_t e;
    req_valid = 1'b1;
    op = o; addr = a; wdata = d; pc_in = p;
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = OP_NOP;
    e.d = '0; e.p = '0; e.o = 1'b0; e.u = 1'b0;
    case (o)
      OP_LOAD: begin e.d = m_mem[a]; sb.push_back(e); end
      OP_STORE: begin m_mem[a] = d; sb.push_back(e); end
      OP_PUSH: begin
        if (m_sp < 1) e.o = 1'b1;
        else begin m_sp--; m_mem[m_sp] = d; end
        sb.push_back(e);
      end
      OP_POP: begin
        if (m_sp > 1023) e.u = 1'b1;
        else begin e.d = m_mem[m_sp]; m_sp++; end
        sb.push_back(e);
      end
      OP_PUSH_PC: begin
        if (m_sp < 2) e.o = 1'b1;
        else begin
          m_mem[m_sp-1] = p[31:16];
          m_mem[m_sp-2] = p[15:0];
          m_sp -= 2;
        end
        sb.push_back(e);
      end
      OP_POP_PC: begin
        if (m_sp > 1022) e.u = 1'b1;
        else begin
          e.p = {m_mem[m_sp+1], m_mem[m_sp]};
          m_sp += 2;
        end
        sb.push_back(e);
      end
      default: ;
    endcase
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_sp", 64'(sp), 64'(1024));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_pc", 64'(rsp_pc), 64'(0));
    chk("rst_exc", 64'({exc_overflow, exc_underflow}), 64'(0));

    // Pop from empty stack
    send(OP_POP, '0, '0, '0);
    chk("pop_empty_sp", 64'(sp), 64'(1024));
    drain("drain_pop_empty");

    // STORE then LOAD, with load latency
    send(OP_STORE, 10'h005, 16'hBEEF, '0);
    send(OP_LOAD, 10'h005, '0, '0);
    chk("load_latency", 64'(rsp_valid), 64'(1));
    chk("load_data_direct", 64'(rsp_data), 64'(16'hBEEF));
    chk("load_sp", 64'(sp), 64'(1024));
    drain("drain_load");

    // PUSH_PC: ready low for exactly one cycle, response one cycle later
    send(OP_PUSH_PC, '0, '0, 32'h1234_5678);
    chk("pushpc_ready_low", 64'(req_ready), 64'(0));
    chk("pushpc_no_early_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    chk("pushpc_ready_back", 64'(req_ready), 64'(1));
    chk("pushpc_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("pushpc_sp", 64'(sp), 64'(1022));
    send(OP_LOAD, 10'd1023, '0, '0);
    send(OP_LOAD, 10'd1022, '0, '0);
    drain("drain_pushpc");
    chk("mem1023_upper", 64'(m_mem[1023]), 64'(16'h1234));
    send(OP_POP_PC, '0, '0, '0);
    drain("drain_poppc");
    chk("poppc_sp", 64'(sp), 64'(1024));

    // Back-to-back push/pop
    send(OP_PUSH, '0, 16'h0001, '0);
    send(OP_PUSH, '0, 16'h0002, '0);
    send(OP_POP, '0, '0, '0);
    send(OP_POP, '0, '0, '0);
    drain("drain_b2b");
    chk("b2b_sp", 64'(sp), 64'(1024));

    // POP_PC with a single word on the stack
    send(OP_PUSH, '0, 16'h7777, '0);
    send(OP_POP_PC, '0, '0, '0);
    drain("drain_poppc_unf");
    chk("poppc_unf_sp", 64'(sp), 64'(1023));
    send(OP_POP, '0, '0, '0);
    drain("drain_restore");

    // NOP and reserved op: no response, no state change
    send(OP_NOP, 10'h005, 16'h1111, '0);
    send(OP_RSVD, 10'h005, 16'h2222, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("nop_sp", 64'(sp), 64'(1024));
    send(OP_LOAD, 10'h005, '0, '0);
    drain("drain_nop");

    // Reset during the XFER cycle of PUSH_PC
    req_valid = 1'b1; op = OP_PUSH_PC; pc_in = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0; op = OP_NOP;
    reset = 1'b1;
    m_mem[1023] = 16'hCAFE;
    @(posedge clk); #1;
    reset = 1'b0;
    m_sp = 1024;
    chk("abort_sp", 64'(sp), 64'(1024));
    chk("abort_ready", 64'(req_ready), 64'(1));
    chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    chk("abort_no_rsp_late", 64'(rsp_valid), 64'(0));
    send(OP_LOAD, 10'd1023, '0, '0);
    send(OP_LOAD, 10'd1022, '0, '0);
    drain("drain_abort");

    // Fill to sp=1, then overflow boundaries
    for (int i = 0; i < 1023; i++) send(OP_PUSH, '0, 16'(i + 256), '0);
    drain("drain_fill");
    chk("fill_sp", 64'(sp), 64'(1));
    send(OP_PUSH_PC, '0, '0, 32'hDEAD_BEEF);
    drain("drain_pushpc_ovf");
    chk("pushpc_ovf_sp", 64'(sp), 64'(1));
    send(OP_PUSH, '0, 16'hAAAA, '0);
    chk("last_push_sp", 64'(sp), 64'(0));
    send(OP_LOAD, 10'd0, '0, '0);
    send(OP_PUSH, '0, 16'h5555, '0);
    chk("push_ovf_sp", 64'(sp), 64'(0));
    send(OP_LOAD, 10'd1023, '0, '0);
    send(OP_POP_PC, '0, '0, '0);
    drain("drain_full");
    chk("full_poppc_sp", 64'(sp), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_memory_unit.md
Name: stack_memory_unit

Overview:
- Parametrised data-memory/stack unit for the memory stage. It is the successor to the fixed 16-bit, 1K-word stage memory.
- Serves word LOAD/STORE, single-word PUSH/POP, and multi-word PUSH_PC/POP_PC. PC transfers are sequenced over several cycles by an internal FSM.
- Adds a valid/ready request handshake, a one-cycle response pulse, and stack overflow/underflow detection with no side effects on fault.

Parameters:
- DATA_W, 16, memory word width in bits.
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words.
- PC_W, 32, program-counter width. Must be a multiple of DATA_W; WORDS = PC_W/DATA_W (must be >= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH_PC, 6 POP_PC, 7 reserved (treated as NOP).
- addr  in  ADDR_W  LOAD/STORE word address.
- wdata  in  DATA_W  STORE/PUSH data.
- pc_in  in  PC_W  PUSH_PC value.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  LOAD/POP result; 0 for all other ops.
- rsp_pc  out  PC_W  POP_PC result; 0 for all other ops.
- exc_overflow  out  1  qualified by rsp_valid.
- exc_underflow  out  1  qualified by rsp_valid.
- sp  out  ADDR_W+1  stack pointer; DEPTH means the stack is empty.

Behaviour:
- Reset:
  - sp=DEPTH, FSM=IDLE, req_ready=1.
  - rsp_valid, rsp_data, rsp_pc and both exc outputs = 0.
  - Memory contents are not cleared.
- Handshake:
  - A request is accepted on a posedge where req_valid & req_ready.
  - req_ready = (state==IDLE). It drops only during XFER.
- FSM states: IDLE, XFER.
  - XFER counts the remaining words (0..WORDS-1).
- Stack convention: full-descending, pre-decrement push, post-increment pop.
  - Push: sp <= sp-1; mem[sp-1] <= word.
  - Pop: word <= mem[sp]; sp <= sp+1.
- LOAD/STORE/PUSH/POP:
  - All state effects happen on the accept edge.
  - rsp_valid is high in the following cycle with the registered result.
  - Back-to-back accepts on consecutive cycles are legal.
- PUSH_PC:
  - The most-significant word is written first, one word per cycle. The accept edge writes word WORDS-1; the XFER cycles write the remaining words.
  - rsp_valid is high in the cycle after the last write.
  - Total occupancy is WORDS cycles; response latency is WORDS cycles after accept.
- POP_PC:
  - One word is popped per cycle, starting at the top of the stack (least-significant word).
  - Each word is shifted into an internal PC_W register: shreg <= {word, shreg[PC_W-1:DATA_W]}.
  - After WORDS pops, rsp_pc=shreg and rsp_valid pulses the following cycle.
- Fault checks are performed atomically at accept, for n = 1 (PUSH/POP) or n = WORDS (PC ops):
  - Overflow when a push has sp < n.
  - Underflow when a pop has sp > DEPTH-n.
  - On fault: no memory write, sp unchanged, no XFER entered.
  - rsp_valid=1 next cycle with the matching exc bit set, rsp_data=0 and rsp_pc=0.
- WORDS==1: PUSH_PC/POP_PC behave exactly like PUSH/POP with the full PC, and never enter XFER.
- NOP/reserved op: accepted, produces no response and no state change.
- Reset asserted mid-XFER:
  - Aborts the transfer and discards partial words; no rsp_valid.
  - sp=DEPTH and the unit is ready in the next cycle.
  - Words already written remain in memory.
- Reset has priority over any request in the same cycle.

Test Plan:
- STORE addr=0x005 wdata=0xBEEF, then LOAD 0x005 -> rsp_valid the cycle after the LOAD accept, rsp_data=0xBEEF, sp=1024.
- PUSH_PC pc_in=0x12345678 -> req_ready low for 1 cycle; mem[1023]=0x1234, mem[1022]=0x5678, sp=1022. Then POP_PC -> rsp_pc=0x12345678, sp=1024.
- POP immediately after reset -> rsp_valid with exc_underflow=1, rsp_data=0, sp=1024. POP_PC with sp=1023 -> exc_underflow=1, sp stays 1023.
- 1023 PUSHes (sp=1), then PUSH_PC -> exc_overflow=1, sp=1, no write. Then PUSH 0xAAAA -> sp=0, mem[0]=0xAAAA. Next PUSH -> exc_overflow=1.
- PUSH 0x0001, PUSH 0x0002, POP, POP on consecutive cycles -> POP responses 0x0002 then 0x0001, sp=1024, no exc.
- Reset asserted in the XFER cycle of PUSH_PC -> no rsp_valid, sp=1024, req_ready=1 on the next cycle, mem[1023]=upper word retained.
